chan_fifo_bridge: RTL and testbench

- Sits directly downstream of the FX2 comm block's channel interface, same clock domain.
- Claims one data channel (CHAN_ADDR) and one status channel (CHAN_ADDR+1).
- Buffers host writes into a host-to-FPGA FIFO (h2f) with a valid/ready drain port for application logic.
- Buffers application data into an FPGA-to-host FIFO (f2h) that is served on host reads.

---
 rtl/chan_fifo_bridge_pkg.sv | 23 ++
 rtl/chan_fifo_bridge_if.sv | 49 ++++
 rtl/chan_fifo_bridge_fifo_fwft.sv | 94 +++++++++
 rtl/chan_fifo_bridge.sv | 124 ++++++++++++
 tb/tb_chan_fifo_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/chan_fifo_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chan_fifo_bridge_pkg
// Description : Shared widths, channel offsets and helpers for the channel
//               FIFO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package chan_fifo_bridge_pkg;

    // Width of the comm block's channel address bus
    localparam int CHAN_ADDR_W   = 7;
    // Width of every data path through the bridge
    localparam int DATA_W        = 8;
    // The status channel sits this many addresses above the data channel
    localparam int STATUS_OFFSET = 1;

    // Clamp an occupancy value so it fits in one status byte
    function automatic logic [DATA_W-1:0] sat_to_byte(input logic [15:0] value);
        return (value > 16'h00FF) ? 8'hFF : value[DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : chan_fifo_bridge_if
// Description : Channel-side and application-side signal bundle of the
//               bridge. The master modport is the environment (comm block
//               plus application logic); the slave modport is the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface chan_fifo_bridge_if;
    import chan_fifo_bridge_pkg::*;

    // Comm block channel interface
    logic [CHAN_ADDR_W-1:0] chanAddr_in;
    logic [DATA_W-1:0]      chanData_in;
    logic                   chanWrite_in;
    logic                   chanGotRoom_out;
    logic [DATA_W-1:0]      chanData_out;
    logic                   chanRead_in;
    logic                   chanGotData_out;

    // Application side of the host-to-FPGA FIFO
    logic [DATA_W-1:0]      h2fData_out;
    logic                   h2fValid_out;
    logic                   h2fReady_in;

    // Application side of the FPGA-to-host FIFO
    logic [DATA_W-1:0]      f2hData_in;
    logic                   f2hValid_in;
    logic                   f2hReady_out;

    // Sticky protocol violation flag
    logic                   protoErr_out;

    modport master (
        output chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
        output h2fReady_in, f2hData_in, f2hValid_in,
        input  chanGotRoom_out, chanData_out, chanGotData_out,
        input  h2fData_out, h2fValid_out, f2hReady_out, protoErr_out
    );

    modport slave (
        input  chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
        input  h2fReady_in, f2hData_in, f2hValid_in,
        output chanGotRoom_out, chanData_out, chanGotData_out,
        output h2fData_out, h2fValid_out, f2hReady_out, protoErr_out
    );

endinterface
`default_nettype wire

// File: rtl/chan_fifo_bridge_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft
// Description : First-word-fall-through byte FIFO with 2^DEPTH_LOG2 entries.
//               The head entry is driven straight from storage; a push into
//               an empty FIFO shows up on the output the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft
    import chan_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk_in,
    input  wire logic                  reset_in,
    input  wire logic [DATA_W-1:0]     push_data_i,
    input  wire logic                  push_valid_i,
    output logic                       push_ready_o,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic                       pop_valid_o,
    input  wire logic                  pop_ready_i,
    output logic [DEPTH_LOG2:0]        count_o
);

    localparam int                  C_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL  = (DEPTH_LOG2+1)'(C_DEPTH);

    generate
        if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 > 8)) begin : g_depth_check
            $error("fifo_fwft: DEPTH_LOG2 must lie in 1..8");
        end
    endgenerate

    logic [DATA_W-1:0]     mem_q [C_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (count_q == C_FULL);
    assign w_empty = (count_q == '0);
    // Full blocks pushes and empty blocks pops; both may proceed together
    assign w_push  = push_valid_i & ~w_full;
    assign w_pop   = pop_ready_i  & ~w_empty;

    assign push_ready_o = ~w_full;
    assign pop_valid_o  = ~w_empty;
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    // Next pointer and occupancy values; pointers wrap at the FIFO depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards everything in flight
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are meaningless until the pointers cover them
    always_ff @(posedge clk_in) begin
        if (!reset_in && w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chan_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : chan_fifo_bridge
// Description : Bridges one comm-block data channel (CHAN_ADDR) and its
//               status channel (CHAN_ADDR+1) onto a host-to-FPGA FIFO and an
//               FPGA-to-host FIFO, with a sticky protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_fifo_bridge
    import chan_fifo_bridge_pkg::*;
#(
    parameter logic [CHAN_ADDR_W-1:0] CHAN_ADDR  = 7'd0,
    parameter int                     DEPTH_LOG2 = 4
) (
    input  wire logic          clk_in,
    input  wire logic          reset_in,
    chan_fifo_bridge_if.slave  bus
);

    // Status channel address wraps within the 7-bit channel space
    localparam logic [CHAN_ADDR_W-1:0] C_STATUS_ADDR =
        CHAN_ADDR + CHAN_ADDR_W'(STATUS_OFFSET);

    logic w_sel_data;
    logic w_sel_status;

    logic                w_h2f_push_ready;
    logic [DATA_W-1:0]   w_h2f_head;
    logic                w_h2f_valid;
    logic [DEPTH_LOG2:0] w_h2f_count;

    logic                w_f2h_push_ready;
    logic [DATA_W-1:0]   w_f2h_head;
    logic                w_f2h_valid;
    logic [DEPTH_LOG2:0] w_f2h_count;

    logic [DATA_W-1:0]   w_status_byte;
    logic                w_got_room;
    logic                w_got_data;
    logic [DATA_W-1:0]   w_chan_data;

    logic protoErr_q, protoErr_d;

    assign w_sel_data   = (bus.chanAddr_in == CHAN_ADDR);
    assign w_sel_status = (bus.chanAddr_in == C_STATUS_ADDR);

    // Host writes on the data channel feed h2f; the application drains it
    fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_h2f (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .push_data_i  (bus.chanData_in),
        .push_valid_i (w_sel_data & bus.chanWrite_in),
        .push_ready_o (w_h2f_push_ready),
        .pop_data_o   (w_h2f_head),
        .pop_valid_o  (w_h2f_valid),
        .pop_ready_i  (bus.h2fReady_in),
        .count_o      (w_h2f_count)
    );

    // The application fills f2h; host reads on the data channel drain it
    fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_f2h (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .push_data_i  (bus.f2hData_in),
        .push_valid_i (bus.f2hValid_in),
        .push_ready_o (w_f2h_push_ready),
        .pop_data_o   (w_f2h_head),
        .pop_valid_o  (w_f2h_valid),
        .pop_ready_i  (w_sel_data & bus.chanRead_in),
        .count_o      (w_f2h_count)
    );

    assign w_status_byte = sat_to_byte(16'(w_h2f_count));

    // Channel-side output mux: data channel, status channel or unclaimed
    always_comb begin
        w_got_room  = 1'b0;
        w_got_data  = 1'b0;
        w_chan_data = '0;
        if (w_sel_data) begin
            w_got_room  = w_h2f_push_ready;
            w_got_data  = w_f2h_valid;
            w_chan_data = w_f2h_head;
        end else if (w_sel_status) begin
            w_got_room  = 1'b1;
            w_got_data  = 1'b1;
            w_chan_data = w_status_byte;
        end
    end

    // Flag a host write into a full h2f or a host read from an empty f2h
    always_comb begin
        protoErr_d = protoErr_q;
        if (w_sel_data && bus.chanWrite_in && !w_h2f_push_ready) begin
            protoErr_d = 1'b1;
        end
        if (w_sel_data && bus.chanRead_in && !w_f2h_valid) begin
            protoErr_d = 1'b1;
        end
    end

    // Sticky error register, cleared only by reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            protoErr_q <= 1'b0;
        end else begin
            protoErr_q <= protoErr_d;
        end
    end

    assign bus.chanGotRoom_out = w_got_room;
    assign bus.chanGotData_out = w_got_data;
    assign bus.chanData_out    = w_chan_data;
    assign bus.h2fData_out     = w_h2f_head;
    assign bus.h2fValid_out    = w_h2f_valid;
    assign bus.f2hReady_out    = w_f2h_push_ready;
    assign bus.protoErr_out    = protoErr_q;

endmodule
`default_nettype wire

// File: tb/tb_chan_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_fifo_bridge
// Description : Self-checking bench for chan_fifo_bridge (CHAN_ADDR=5,
//               DEPTH_LOG2=4): a table of directed vectors followed by
//               hand-written sequences for full, wrap and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_fifo_bridge;

    localparam logic [6:0] C_ADDR = 7'd5;
    localparam logic [6:0] C_STAT = 7'd6;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    chan_fifo_bridge_if bif ();

    chan_fifo_bridge #(
        .CHAN_ADDR  (C_ADDR),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bif)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [6:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic       rd;
        logic       hrdy;
        logic       fvld;
        logic [7:0] fdata;
        logic       e_room;
        logic       e_gdata;
        logic       chk_cd;
        logic [7:0] e_cd;
        logic       e_hv;
        logic [7:0] e_hd;
        logic       e_frdy;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [6:0] addr, input logic wr, input logic [7:0] wdata,
        input logic rd, input logic hrdy, input logic fvld, input logic [7:0] fdata,
        input logic e_room, input logic e_gdata, input logic chk_cd,
        input logic [7:0] e_cd, input logic e_hv, input logic [7:0] e_hd,
        input logic e_frdy, input logic e_err);
        vec_t v;
        v.addr = addr; v.wr = wr; v.wdata = wdata; v.rd = rd; v.hrdy = hrdy;
        v.fvld = fvld; v.fdata = fdata; v.e_room = e_room; v.e_gdata = e_gdata;
        v.chk_cd = chk_cd; v.e_cd = e_cd; v.e_hv = e_hv; v.e_hd = e_hd;
        v.e_frdy = e_frdy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] addr, input logic wr, input logic [7:0] wdata,
                         input logic rd, input logic hrdy, input logic fvld,
                         input logic [7:0] fdata);
        bif.chanAddr_in  = addr;
        bif.chanWrite_in = wr;
        bif.chanData_in  = wdata;
        bif.chanRead_in  = rd;
        bif.h2fReady_in  = hrdy;
        bif.f2hValid_in  = fvld;
        bif.f2hData_in   = fdata;
        #1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] nxt;
        logic       wr;
        logic       rdy;
        logic       do_push;
        logic       do_pop;

        // addr wr wdata rd hrdy fvld fdata | room gdata chk_cd cd hv hd frdy err
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,1,8'h11,0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,1,8'h22,0,0,0,8'h00, 1,0,0,8'h00, 1,8'h11,1,0));
        vq.push_back(mk(C_ADDR,1,8'h33,0,0,0,8'h00, 1,0,0,8'h00, 1,8'h11,1,0));
        vq.push_back(mk(C_STAT,0,8'h00,0,0,0,8'h00, 1,1,1,8'h03, 1,8'h11,1,0));
        vq.push_back(mk(C_STAT,1,8'h99,1,0,0,8'h00, 1,1,1,8'h03, 1,8'h11,1,0));
        vq.push_back(mk(C_STAT,0,8'h00,0,0,0,8'h00, 1,1,1,8'h03, 1,8'h11,1,0));
        vq.push_back(mk(7'd9,  1,8'h55,1,0,0,8'h00, 0,0,1,8'h00, 1,8'h11,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00, 1,8'h11,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00, 1,8'h22,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00, 1,8'h33,1,0));
        vq.push_back(mk(C_STAT,0,8'h00,0,0,0,8'h00, 1,1,1,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,1,8'hA0, 1,0,0,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,1,8'hA1, 1,1,1,8'hA0, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,1,8'hA2, 1,1,1,8'hA0, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,1,8'hA3, 1,1,1,8'hA0, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,1,0,0,8'h00, 1,1,1,8'hA0, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,1,0,0,8'h00, 1,1,1,8'hA1, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,1,0,0,8'h00, 1,1,1,8'hA2, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,1,0,0,8'h00, 1,1,1,8'hA3, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,1,0,0,8'h00, 1,0,0,8'h00, 0,8'h00,1,0));
        vq.push_back(mk(C_ADDR,0,8'h00,0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00,1,1));

        do_reset();

        // Table: drive each vector, compare pre-edge outputs, then clock it in
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].addr, vq[i].wr, vq[i].wdata, vq[i].rd, vq[i].hrdy,
                  vq[i].fvld, vq[i].fdata);
            chk($sformatf("v%0d room", i),  16'(bif.chanGotRoom_out), 16'(vq[i].e_room));
            chk($sformatf("v%0d gdata", i), 16'(bif.chanGotData_out), 16'(vq[i].e_gdata));
            if (vq[i].chk_cd)
                chk($sformatf("v%0d cdata", i), 16'(bif.chanData_out), 16'(vq[i].e_cd));
            chk($sformatf("v%0d hvalid", i), 16'(bif.h2fValid_out), 16'(vq[i].e_hv));
            if (vq[i].e_hv)
                chk($sformatf("v%0d hdata", i), 16'(bif.h2fData_out), 16'(vq[i].e_hd));
            chk($sformatf("v%0d frdy", i), 16'(bif.f2hReady_out), 16'(vq[i].e_frdy));
            chk($sformatf("v%0d err", i),  16'(bif.protoErr_out), 16'(vq[i].e_err));
            step();
        end

        // h2f full: 16 writes, then a 17th write raises protoErr
        do_reset();
        chk("fullA rst err", 16'(bif.protoErr_out), 16'd0);
        for (int i = 0; i < 16; i++) begin
            drive(C_ADDR, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("fullA room%0d", i), 16'(bif.chanGotRoom_out), 16'd1);
            step();
        end
        drive(C_ADDR, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullA room16", 16'(bif.chanGotRoom_out), 16'd0);
        chk("fullA err pre", 16'(bif.protoErr_out), 16'd0);
        step();
        drive(C_STAT, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullA err post", 16'(bif.protoErr_out), 16'd1);
        chk("fullA status", 16'(bif.chanData_out), 16'h10);
        chk("fullA head", 16'(bif.h2fData_out), 16'h40);
        for (int i = 0; i < 16; i++) begin
            drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("fullA hv%0d", i), 16'(bif.h2fValid_out), 16'd1);
            chk($sformatf("fullA hd%0d", i), 16'(bif.h2fData_out), 16'(8'h40 + 8'(i)));
            step();
        end
        drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullA drained", 16'(bif.h2fValid_out), 16'd0);

        // f2h full with a simultaneous push attempt and host pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h80 + 8'(i));
            chk($sformatf("fullB frdy%0d", i), 16'(bif.f2hReady_out), 16'd1);
            step();
        end
        drive(C_ADDR, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hEE);
        chk("fullB frdy full", 16'(bif.f2hReady_out), 16'd0);
        chk("fullB head", 16'(bif.chanData_out), 16'h80);
        step();
        drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullB frdy after", 16'(bif.f2hReady_out), 16'd1);
        for (int i = 0; i < 15; i++) begin
            drive(C_ADDR, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("fullB gd%0d", i), 16'(bif.chanGotData_out), 16'd1);
            chk($sformatf("fullB cd%0d", i), 16'(bif.chanData_out), 16'(8'h81 + 8'(i)));
            step();
        end
        drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullB empty", 16'(bif.chanGotData_out), 16'd0);
        chk("fullB err", 16'(bif.protoErr_out), 16'd0);

        // Wrap: 40 bytes through h2f with concurrent push/pop, then reset
        do_reset();
        nxt = 8'h00;
        for (int c = 0; c < 45; c++) begin
            wr  = (nxt < 8'd40);
            rdy = ((c % 3) != 0);
            drive(C_ADDR, wr, nxt, 1'b0, rdy, 1'b0, 8'h00);
            chk($sformatf("wrap room c%0d", c), 16'(bif.chanGotRoom_out), 16'(q.size() < 16));
            chk($sformatf("wrap hv c%0d", c), 16'(bif.h2fValid_out), 16'(q.size() != 0));
            if (q.size() != 0)
                chk($sformatf("wrap hd c%0d", c), 16'(bif.h2fData_out), 16'(q[0]));
            do_push = wr && (q.size() < 16);
            do_pop  = rdy && (q.size() != 0);
            step();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
        end
        drive(C_ADDR, 1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 8'hDD);
        chk("wrap busy before rst", 16'(bif.h2fValid_out), 16'd1);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        q.delete();
        drive(C_STAT, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap rst hv", 16'(bif.h2fValid_out), 16'd0);
        chk("wrap rst status", 16'(bif.chanData_out), 16'h00);
        chk("wrap rst room", 16'(bif.chanGotRoom_out), 16'd1);
        drive(C_ADDR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap rst gdata", 16'(bif.chanGotData_out), 16'd0);
        chk("wrap rst frdy", 16'(bif.f2hReady_out), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
